seq_scan_ctrl: RTL

Round-robin controller that shares one external 1011 serial sequence detector among N requesters. It accepts a W-bit word from the granted requester and clears the detector. It then shifts the word MSB-first into the detector, counts detector output pulses and returns a match count plus first-match position, tagged with the requester id. The block sits between the parallel requester ports and the detector's inp/reset/out pins.

---
 rtl/seq_scan_ctrl_if.sv | 33 +++
 rtl/seq_scan_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl_if.sv
// Bundles the requester, detector and result pins of seq_scan_ctrl.
// The master modport is the controller side; slave is the surrounding environment.
interface seq_scan_ctrl_if #(
    parameter int N = 4,
    parameter int W = 16
);
    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(W + 1);
    localparam int POS_W = $clog2(W);

    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             det_inp;
    logic             det_rst_n;
    logic             det_out;
    logic             res_valid;
    logic             res_ready;
    logic [ID_W-1:0]  res_id;
    logic [CNT_W-1:0] res_count;
    logic [POS_W-1:0] res_first;
    logic             busy;

    modport master (
        input  req_valid, req_data, det_out, res_ready,
        output req_ready, det_inp, det_rst_n, res_valid, res_id, res_count, res_first, busy
    );

    modport slave (
        output req_valid, req_data, det_out, res_ready,
        input  req_ready, det_inp, det_rst_n, res_valid, res_id, res_count, res_first, busy
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Round-robin front end that time-shares one external 1011 detector among N requesters,
// serialising each accepted word MSB-first and reporting match count and first-match position.
module seq_scan_ctrl #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic            clk,
    input  logic            reset,
    seq_scan_ctrl_if.master bus
);
    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(W + 1);
    localparam int POS_W = $clog2(W);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_e;

    state_e           state_q,  state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q,     id_d;
    logic [W-1:0]     shift_q,  shift_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [POS_W-1:0] first_q,  first_d;
    logic [POS_W-1:0] k_q,      k_d;
    logic             found_q,  found_d;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [N-1:0]     req_ready_c;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int off = 1; off <= N; off++) begin
            if (!grant_vld && bus.req_valid[(int'(rr_ptr_q) + off) % N]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr_q) + off) % N);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        shift_d     = shift_q;
        count_d     = count_q;
        first_d     = first_q;
        k_d         = k_q;
        found_d     = found_q;
        req_ready_c = '0;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready_c[grant_idx] = 1'b1;
                    shift_d  = bus.req_data[int'(grant_idx)*W +: W];
                    id_d     = grant_idx;
                    rr_ptr_d = grant_idx;
                    state_d  = CLR;
                end
            end
            CLR: begin
                count_d = '0;
                first_d = '0;
                found_d = 1'b0;
                k_d     = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_d = {shift_q[W-2:0], 1'b0};
                k_d     = k_q + POS_W'(1);
                // A pulse seen at step k was caused by the bit shifted in at step k-1.
                if (bus.det_out) begin
                    count_d = count_q + CNT_W'(1);
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = k_q - POS_W'(1);
                    end
                end
                if (k_q == POS_W'(W - 1)) state_d = DRAIN;
            end
            DRAIN: begin
                if (bus.det_out) begin
                    count_d = count_q + CNT_W'(1);
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = POS_W'(W - 1);
                    end
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= ID_W'(N - 1);
            id_q     <= '0;
            shift_q  <= '0;
            count_q  <= '0;
            first_q  <= '0;
            k_q      <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            first_q  <= first_d;
            k_q      <= k_d;
            found_q  <= found_d;
        end
    end

    // Outputs are forced to their idle values while reset is held, so the detector clears on the same edge.
    assign bus.req_ready = reset ? req_ready_c : '0;
    assign bus.det_inp   = reset && (state_q == SHIFT) && shift_q[W-1];
    assign bus.det_rst_n = reset && (state_q != CLR);
    assign bus.res_valid = reset && (state_q == DONE);
    assign bus.res_id    = reset ? id_q    : '0;
    assign bus.res_count = reset ? count_q : '0;
    assign bus.res_first = reset ? first_q : '0;
    assign bus.busy      = reset && (state_q != IDLE);
endmodule
